// File: rtl/mem_bist_if.sv
// Handshake bus between the BIST initiator and the single-port-pair RAM under test.
// The RAM samples the enables on negedge and answers through the ready/data lines.
interface mem_bist_if #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4
);
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic [ADDRESS_SIZE-1:0] mem_r_addr;
    logic [ADDRESS_SIZE-1:0] mem_w_addr;
    logic [WORD_SIZE-1:0]    mem_w_data;
    logic                    mem_r_ready;
    logic                    mem_w_ready;
    logic [WORD_SIZE-1:0]    mem_r_data;

    modport master (
        output mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data,
        input  mem_r_ready, mem_w_ready, mem_r_data
    );

    modport slave (
        input  mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data,
        output mem_r_ready, mem_w_ready, mem_r_data
    );
endinterface

// File: rtl/mem_bist.sv
// Memory BIST initiator: INIT-check, WRITE (addr^SEED) and VERIFY sweeps over the RAM,
// reporting pass, the first mismatch or a handshake timeout. All outputs registered.
module mem_bist #(
    parameter int          WORD_SIZE    = 8,
    parameter int          ADDRESS_SIZE = 4,
    parameter int          MEMORY_QTY   = 16,
    parameter int unsigned WORD_INIT    = 0,
    parameter int unsigned SEED         = 'hA5,
    parameter int          TIMEOUT_SIZE = 8,
    parameter int          TIMEOUT      = 200
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    mem_bist_if.master              mem,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [1:0]              fail_phase,
    output logic [ADDRESS_SIZE-1:0] fail_addr,
    output logic [WORD_SIZE-1:0]    fail_data
);
    localparam logic [WORD_SIZE-1:0]    INIT_W    = WORD_SIZE'(WORD_INIT);
    localparam logic [WORD_SIZE-1:0]    SEED_W    = WORD_SIZE'(SEED);
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_QTY - 1);
    localparam logic [TIMEOUT_SIZE-1:0] WD_LAST   = TIMEOUT_SIZE'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SYNC, REQ, WAIT_HI, FINISH} state_t;
    typedef enum logic [1:0] {PH_INIT = 2'd0, PH_WRITE = 2'd1, PH_VERIFY = 2'd2} phase_t;

    // Next request to place on the bus when entering REQ.
    typedef struct packed {
        logic                    rd;
        logic [ADDRESS_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0]    data;
    } req_t;

    state_t                  state;
    phase_t                  phase;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [TIMEOUT_SIZE-1:0] wdog;

    logic                    last;
    logic [ADDRESS_SIZE-1:0] adv_addr;
    phase_t                  adv_phase;
    phase_t                  iss_phase;
    req_t                    iss;
    logic [WORD_SIZE-1:0]    expect_data;
    logic                    op_ready;
    logic                    mismatch;
    logic                    wd_expired;

    always_comb begin
        last        = (addr == LAST_ADDR);
        adv_addr    = last ? '0 : addr + 1'b1;
        adv_phase   = last ? phase_t'(phase + 2'd1) : phase;
        // From SYNC the first request reuses the current address/phase.
        iss_phase   = (state == SYNC) ? phase : adv_phase;
        iss.addr    = (state == SYNC) ? addr : adv_addr;
        iss.rd      = (iss_phase != PH_WRITE);
        iss.data    = WORD_SIZE'(iss.addr) ^ SEED_W;
        expect_data = (phase == PH_INIT) ? INIT_W : (WORD_SIZE'(addr) ^ SEED_W);
        op_ready    = (phase == PH_WRITE) ? mem.mem_w_ready : mem.mem_r_ready;
        mismatch    = (phase != PH_WRITE) && (mem.mem_r_data != expect_data);
        wd_expired  = (wdog == WD_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= PH_INIT;
            addr           <= '0;
            wdog           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_phase     <= '0;
            fail_addr      <= '0;
            fail_data      <= '0;
            mem.mem_r_en   <= 1'b0;
            mem.mem_w_en   <= 1'b0;
            mem.mem_r_addr <= '0;
            mem.mem_w_addr <= '0;
            mem.mem_w_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SYNC;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        fail_phase <= '0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        phase      <= PH_INIT;
                        addr       <= '0;
                        wdog       <= '0;
                    end
                end
                SYNC: begin
                    if (mem.mem_r_ready && mem.mem_w_ready) begin
                        state        <= REQ;
                        mem.mem_r_en <= iss.rd;
                        mem.mem_w_en <= !iss.rd;
                        if (iss.rd) begin
                            mem.mem_r_addr <= iss.addr;
                        end else begin
                            mem.mem_w_addr <= iss.addr;
                            mem.mem_w_data <= iss.data;
                        end
                    end else if (wd_expired) begin
                        state      <= FINISH;
                        timeout    <= 1'b1;
                        fail_phase <= phase;
                        fail_addr  <= addr;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                REQ: begin
                    // Enables are one-cycle pulses; the RAM has latched them at the negedge.
                    mem.mem_r_en <= 1'b0;
                    mem.mem_w_en <= 1'b0;
                    wdog         <= '0;
                    state        <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (op_ready) begin
                        if (mismatch) begin
                            state      <= FINISH;
                            fail_phase <= phase;
                            fail_addr  <= addr;
                            fail_data  <= mem.mem_r_data;
                        end else if (last && phase == PH_VERIFY) begin
                            state <= FINISH;
                            pass  <= 1'b1;
                        end else begin
                            addr         <= adv_addr;
                            phase        <= adv_phase;
                            state        <= REQ;
                            mem.mem_r_en <= iss.rd;
                            mem.mem_w_en <= !iss.rd;
                            if (iss.rd) begin
                                mem.mem_r_addr <= iss.addr;
                            end else begin
                                mem.mem_w_addr <= iss.addr;
                                mem.mem_w_data <= iss.data;
                            end
                        end
                    end else if (wd_expired) begin
                        state      <= FINISH;
                        timeout    <= 1'b1;
                        fail_phase <= phase;
                        fail_addr  <= addr;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: behavioural RAM with programmable waits and fault hooks, a sweep-level
// reference model of the request stream and final verdict, and one per-cycle bus monitor.
module tb_mem_bist;
    localparam int WS  = 8;
    localparam int AS  = 4;
    localparam int QTY = 16;
    localparam int TO  = 200;
    localparam logic [WS-1:0] INITW = 8'h00;
    localparam logic [WS-1:0] SEED  = 8'hA5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, timeout;
    logic [1:0]    fail_phase;
    logic [AS-1:0] fail_addr;
    logic [WS-1:0] fail_data;

    mem_bist_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) bus ();

    mem_bist #(
        .WORD_SIZE(WS), .ADDRESS_SIZE(AS), .MEMORY_QTY(QTY), .WORD_INIT(0),
        .SEED('hA5), .TIMEOUT_SIZE(8), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .mem(bus.master),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_phase(fail_phase), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural RAM (acts on negedge) ----------------
    int            read_wait = 0, write_wait = 0, init_len = 20;
    bit            stick_w = 0, corrupt_pre = 0, corrupt_post = 0;
    int            corrupt_addr = 0;
    logic [WS-1:0] corrupt_val = '0;
    logic [WS-1:0] ram [QTY];
    logic          r_rdy, w_rdy, w_stuck;
    logic [WS-1:0] r_dat;
    logic [AS-1:0] rd_addr_q;
    int            rcnt, wcnt, init_cnt, init_done_cyc;

    assign bus.mem_r_ready = r_rdy;
    assign bus.mem_w_ready = w_rdy & !w_stuck;
    assign bus.mem_r_data  = r_dat;

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            r_rdy <= 1'b0; w_rdy <= 1'b0; w_stuck <= 1'b0; r_dat <= '0; rd_addr_q <= '0;
            rcnt <= 0; wcnt <= 0; init_cnt <= 0; init_done_cyc <= 1 << 30;
        end else if (init_cnt < init_len) begin
            ram[init_cnt % QTY] <= INITW;
            init_cnt <= init_cnt + 1;
            if (init_cnt == init_len - 1) begin
                r_rdy <= 1'b1; w_rdy <= 1'b1; init_done_cyc <= cyc;
                if (corrupt_pre) ram[corrupt_addr] <= corrupt_val;
            end
        end else begin
            if (bus.mem_r_en) begin
                r_rdy <= 1'b0; rcnt <= read_wait; rd_addr_q <= bus.mem_r_addr;
            end else if (!r_rdy) begin
                if (rcnt == 0) begin r_rdy <= 1'b1; r_dat <= ram[rd_addr_q]; end
                else rcnt <= rcnt - 1;
            end
            if (bus.mem_w_en) begin
                ram[bus.mem_w_addr] <= bus.mem_w_data;
                w_rdy <= 1'b0; wcnt <= write_wait;
                if (stick_w) w_stuck <= 1'b1;
                if (corrupt_post && bus.mem_w_addr == AS'(QTY - 1)) ram[corrupt_addr] <= corrupt_val;
            end else if (!w_rdy) begin
                if (wcnt == 0) w_rdy <= 1'b1;
                else wcnt <= wcnt - 1;
            end
        end
    end

    // ---------------- sweep-level reference model ----------------
    typedef struct {
        bit            wr;
        logic [AS-1:0] a;
        logic [WS-1:0] d;
        int            lat;
    } op_t;

    op_t           expq[$];
    logic [WS-1:0] mdl_mem [QTY];
    bit            e_pass, e_to;
    logic [1:0]    e_ph;
    logic [AS-1:0] e_fa;
    logic [WS-1:0] e_fd;
    int            e_total, meas_total;

    task automatic build_model();
        bit stop;
        stop = 0; expq.delete(); e_total = 0; e_to = 0; e_ph = 0; e_fa = 0; e_fd = 0;
        for (int ph = 0; ph < 3 && !stop; ph++) begin
            for (int a = 0; a < QTY && !stop; a++) begin
                op_t o;
                logic [WS-1:0] pat, want;
                pat = WS'(a) ^ SEED;
                o.a = AS'(a);
                if (ph == 1) begin
                    o.wr = 1; o.d = pat; mdl_mem[a] = pat;
                    if (stick_w) begin o.lat = 1 + TO; e_to = 1; e_fa = AS'(a); stop = 1; end
                    else o.lat = write_wait + 2;
                end else begin
                    want = (ph == 0) ? INITW : pat;
                    o.wr = 0; o.d = '0; o.lat = read_wait + 2;
                    if (mdl_mem[a] !== want) begin
                        e_ph = 2'(ph); e_fa = AS'(a); e_fd = mdl_mem[a]; stop = 1;
                    end
                end
                expq.push_back(o);
                e_total += o.lat;
            end
            if (ph == 1 && !stop && corrupt_post) mdl_mem[corrupt_addr] = corrupt_val;
        end
        e_pass = !stop;
        e_total += 1;   // done registers one cycle after FINISH is entered
    endtask

    // ---------------- per-cycle bus monitor ----------------
    int            n_ops = 0, first_cyc = 0, last_cyc = 0, last_lat = 0;
    bit            prev_en = 0;
    logic [WS-1:0] obs_wdata [QTY];
    op_t           cur;

    always @(negedge clock) begin
        if (reset) begin
            chk("en_in_reset", {bus.mem_r_en, bus.mem_w_en}, 0);
            prev_en = 1'b0;
        end else if (bus.mem_r_en || bus.mem_w_en) begin
            chk("en_exclusive", bus.mem_r_en & bus.mem_w_en, 0);
            chk("en_single", prev_en, 0);
            if (expq.size() == 0) begin
                chk("unexpected_req", {bus.mem_r_en, bus.mem_w_en}, 0);
            end else begin
                cur = expq.pop_front();
                chk("req_kind", bus.mem_w_en, cur.wr);
                if (cur.wr) begin
                    chk("w_addr", bus.mem_w_addr, cur.a);
                    chk("w_data", bus.mem_w_data, cur.d);
                    obs_wdata[cur.a] = bus.mem_w_data;
                end else begin
                    chk("r_addr", bus.mem_r_addr, cur.a);
                end
                if (n_ops == 0) begin
                    first_cyc = cyc;
                    chk("sync_hold", cyc > init_done_cyc, 1);
                end else begin
                    chk("op_interval", cyc - last_cyc, last_lat);
                end
                last_cyc = cyc; last_lat = cur.lat; n_ops++;
            end
            prev_en = 1'b1;
        end else begin
            prev_en = 1'b0;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic do_reset(input int ilen);
        reset = 1'b1; init_len = ilen;
        for (int a = 0; a < QTY; a++) mdl_mem[a] = INITW;
        if (corrupt_pre) mdl_mem[corrupt_addr] = corrupt_val;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, done, pass, timeout}, 0);
        chk({tag, "_fail"}, {fail_phase, fail_addr, fail_data}, 0);
        chk({tag, "_bus"}, {bus.mem_r_en, bus.mem_w_en, bus.mem_r_addr, bus.mem_w_addr, bus.mem_w_data}, 0);
    endtask

    task automatic run_test(input bit pulse_busy, input bit pulse_fin);
        build_model();
        n_ops = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_pass_clr", pass, 0);
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (pulse_busy && c == 7) start = 1'b1;
            if (pulse_fin && n_ops > 0 && cyc == first_cyc + e_total - 1) start = 1'b1;
        end
        start = 1'b0;
        meas_total = cyc - first_cyc;
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("pass", pass, e_pass);
        chk("timeout", timeout, e_to);
        chk("fail_addr", fail_addr, e_fa);
        if (!e_to) begin
            chk("fail_phase", fail_phase, e_ph);
            chk("fail_data", fail_data, e_fd);
        end
        chk("ops_left", expq.size(), 0);
        chk("latency", meas_total, e_total);
        repeat (5) @(negedge clock);
        chk("done_hold", {done, busy}, 2'b10);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        #2 reset = 1'b1;
        #1 chk_zero("reset");
        do_reset(20);

        // Default RAM, zero waits: full pass.
        run_test(0, 0);
        chk("pin_pass", pass, 1);
        chk("pin_cycles", meas_total, 97);
        chk("pin_wd0", obs_wdata[0], 8'hA5);
        chk("pin_wd1", obs_wdata[1], 8'hA4);
        chk("pin_wd15", obs_wdata[15], 8'hAA);

        // Rerun without reset: RAM still holds the pattern, so INIT fails at word 0.
        run_test(0, 0);
        chk("pin_rerun_phase", fail_phase, 0);
        chk("pin_rerun_data", fail_data, 8'hA5);

        // Slow RAM, plus start pulses while busy and on the FINISH edge.
        read_wait = 2; write_wait = 1;
        do_reset(18);
        run_test(1, 1);
        chk("pin_slow_pass", pass, 1);
        chk("pin_slow_cycles", meas_total, 177);

        // Backdoor corruption of word 5 after the WRITE sweep.
        read_wait = 0; write_wait = 0;
        corrupt_post = 1; corrupt_addr = 5; corrupt_val = 8'h00;
        do_reset(20);
        run_test(0, 0);
        chk("pin_bd_phase", fail_phase, 2);
        chk("pin_bd_addr", fail_addr, 5);
        chk("pin_bd_data", fail_data, 8'h00);
        chk("pin_bd_ops", n_ops, 38);
        corrupt_post = 0;

        // Write-ready stuck low during WRITE.
        stick_w = 1;
        do_reset(20);
        run_test(0, 0);
        chk("pin_to_flag", timeout, 1);
        chk("pin_to_addr", fail_addr, 0);
        chk("pin_to_cycles", meas_total, 234);
        chk("pin_to_ops", n_ops, 17);
        stick_w = 0;

        // Reset during VERIFY at address 9, then a clean rerun.
        do_reset(20);
        build_model();
        n_ops = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int c = 0; c < 3000 && n_ops < 42; c++) @(negedge clock);
        chk("mid_reached", n_ops, 42);
        #2 reset = 1'b1;
        #1 chk_zero("mid_reset");
        expq.delete();
        do_reset(20);
        run_test(0, 0);
        chk("pin_after_mid", pass, 1);

        // Randomised runs.
        for (int i = 0; i < 6; i++) begin
            int f;
            f = $urandom_range(0, 2);
            corrupt_pre  = (f == 1);
            corrupt_post = (f == 2);
            corrupt_addr = $urandom_range(0, QTY - 1);
            corrupt_val  = WS'($urandom);
            read_wait    = $urandom_range(0, 3);
            write_wait   = $urandom_range(0, 3);
            do_reset($urandom_range(16, 40));
            run_test(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
